demux: RTL and testbench
========================

# demux

Registered stream demultiplexer: routes one input word to one of `NUM_OUTPUTS` output channels under a valid/ready handshake. Each output has a one-entry holding register, so independent consumers can stall without blocking traffic to the others. It is the distribution counterpart of `mux`. Its flattened output bus uses the same packing as the `mux` input bus, so the two blocks can be chained back-to-back in the datapath.

## Interface
Parameters:
- `NUM_OUTPUTS`, 4: number of output channels, ≥2; need not be a power of two.
- `DATA_WIDTH`, 8: width of one data word.

Ports:
- `i_clk`  in  1  single clock; all state updates on its rising edge.
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `i_valid`  in  1  input word present.
- `o_ready`  out  1  input word accepted this cycle when `i_valid` && `o_ready`.
- `i_data`  in  `DATA_WIDTH`  input word.
- `i_select`  in  `$clog2(NUM_OUTPUTS)`  destination channel; sampled with `i_data`.
- `o_data_bus`  out  `NUM_OUTPUTS*DATA_WIDTH`  channel k at bits `[k*DATA_WIDTH +: DATA_WIDTH]`; channel 0 in the LSBs.
- `o_valid`  out  `NUM_OUTPUTS`  bit k: channel k holds a word.
- `i_ready`  in  `NUM_OUTPUTS`  bit k: consumer k takes the word this cycle.
- `o_err`  out  1  one-cycle pulse: a word with out-of-range select was accepted and dropped.

## Operation
- Per channel k: a data register `slot[k]` and a full flag `full[k]`; `o_valid[k] = full[k]`; `o_data_bus` slice k = `slot[k]`.
- Drain: `full[k]` && `i_ready[k]` at an edge empties channel k, unless a new word for k is loaded at the same edge.
- Accept, in-range `i_select` = s: `o_ready = !full[s] || i_ready[s]` (combinational through `i_ready`). On accept, `slot[s] <= i_data` and `full[s] <= 1`.
- Simultaneous drain and load on the same channel: the old word leaves, the new word loads, and `full` stays 1. This sustains full throughput.
- Accept, `i_select ≥ NUM_OUTPUTS` (only possible for non-power-of-two): `o_ready = 1`, the word is discarded, no slot changes, and `o_err = 1` on the following cycle.
- Channels other than s are unaffected by the accept; they drain independently in the same cycle.
- `i_valid` = 0: `o_ready` still reflects the selected channel. It is informative only; no state change.
- Empty slot keeps its last data (not cleared). Data is meaningful only when `o_valid[k]` = 1.
- No ordering across channels. Per channel, FIFO order is trivially preserved (depth 1).

## Timing
- Reset (async assert, release synchronised by the system): `full` = 0, all slots 0, `o_valid` = 0, `o_data_bus` = 0, `o_err` = 0. `o_ready` then equals 1 for any select.
- Reset mid-transfer: all held words are lost immediately, and outputs go to reset values without waiting for a clock.
- Latency: word accepted at edge t appears on `o_valid`/`o_data_bus` immediately after edge t (1 cycle).
- Throughput: 1 word/cycle while the selected consumer keeps `i_ready` high.
- `o_err` is registered: high for exactly one cycle after the dropping edge.
- `o_ready` has a combinational path from `i_select`, `i_ready`, and `full`. It has none from `i_valid` or `i_data`.

## Configuration
- Macro `DEMUX_BROADCAST_EN`.
- Defined:
  - Adds input port `i_broadcast` (1 bit).
  - When `i_broadcast` = 1, `o_ready = &(~full | i_ready)`. On accept, every slot loads `i_data` and every `full` sets.
  - `i_select` is ignored and `o_err` is never raised for a broadcast.
- Undefined: the port is absent and behaviour is exactly as above.

## Test plan
- Reset, then send 8'hDD/sel 0, 8'hCC/sel 1, 8'hBB/sel 2, 8'hAA/sel 3 with all `i_ready` = 0. Required: `o_ready` = 1 for each, `o_valid` = 4'b1111, `o_data_bus` = 32'hAABBCCDD.
- Channel 1 full, `i_ready[1]` = 0, send sel 1. Required: `o_ready` = 0 and the slot is unchanged. Then raise `i_ready[1]`: the word is accepted the same cycle and `o_valid[1]` stays 1 with the new data.
- `i_ready` all 1, stream 0x01..0x10 to sel 2 on consecutive cycles. Required: one word out per cycle in order, 1-cycle latency, no bubbles.
- `NUM_OUTPUTS` = 3, send 8'h55 with sel 3. Required: `o_ready` = 1, `o_err` pulses for 1 cycle, and `o_valid` is unchanged.
- Assert `i_rst_n` = 0 between edges with 2 slots full. Required: `o_valid` = 0 and `o_data_bus` = 0 immediately, before the next clock.
- `DEMUX_BROADCAST_EN` defined, `i_broadcast` = 1, data 8'h3C, one slot full and not ready. Required: `o_ready` = 0. After that slot drains: accepted, `o_valid` = all 1s, every slice = 8'h3C.

Source files
------------

// File: rtl/demux.sv
// demux: registered stream demultiplexer.
// Routes one input word to one of NUM_OUTPUTS channels under valid/ready.
// Each channel owns a one-entry holding register, so a stalled consumer
// only blocks words addressed to its own channel.
// Output bus packing: channel k at [k*DATA_WIDTH +: DATA_WIDTH], channel 0
// in the LSBs. This matches the mux input bus.
// Optional feature: define DEMUX_BROADCAST_EN to add i_broadcast, which
// copies the input word into every channel at once.

module demux #(
    parameter int NUM_OUTPUTS = 4,
    parameter int DATA_WIDTH  = 8
) (
    input  logic                              i_clk,
    input  logic                              i_rst_n,
`ifdef DEMUX_BROADCAST_EN
    input  logic                              i_broadcast,
`endif
    input  logic                              i_valid,
    output logic                              o_ready,
    input  logic [DATA_WIDTH-1:0]             i_data,
    input  logic [$clog2(NUM_OUTPUTS)-1:0]    i_select,
    output logic [NUM_OUTPUTS*DATA_WIDTH-1:0] o_data_bus,
    output logic [NUM_OUTPUTS-1:0]            o_valid,
    input  logic [NUM_OUTPUTS-1:0]            i_ready,
    output logic                              o_err
);

    localparam int SEL_W = $clog2(NUM_OUTPUTS);

    // Channel count widened by one bit, so out-of-range selects can be
    // detected when NUM_OUTPUTS is not a power of two.
    localparam logic [SEL_W:0] NUM_OUT_W = (SEL_W+1)'(NUM_OUTPUTS);

    logic [DATA_WIDTH-1:0]  slot [NUM_OUTPUTS];
    logic [NUM_OUTPUTS-1:0] full;
    logic [NUM_OUTPUTS-1:0] load;
    logic                   broadcast;
    logic                   sel_in_range;
    logic                   sel_ready;
    logic                   all_ready;
    logic                   accept;
    logic                   drop;
    logic                   err_q;

`ifdef DEMUX_BROADCAST_EN
    assign broadcast = i_broadcast;
`else
    assign broadcast = 1'b0;
`endif

    assign sel_in_range = ({1'b0, i_select} < NUM_OUT_W);

    // Input readiness: depends on select, full flags and consumer ready.
    // It never depends on i_valid or i_data.
    always_comb begin
        // NOTE: every variable assigned in always_comb gets a default first.
        // A path that leaves a variable unassigned would infer a latch.
        sel_ready = 1'b1;
        for (int k = 0; k < NUM_OUTPUTS; k++) begin
            if (sel_in_range && (i_select == SEL_W'(k))) begin
                sel_ready = !full[k] || i_ready[k];
            end
        end
        all_ready = &(~full | i_ready);
        o_ready   = broadcast ? all_ready : sel_ready;
    end

    assign accept = i_valid && o_ready;

    // A word is dropped when it is accepted with a select that names no
    // channel. Broadcast words ignore the select, so they are never dropped.
    assign drop = accept && !broadcast && !sel_in_range;

    // Per-channel load strobes for the accepted word.
    always_comb begin
        load = '0;
        for (int k = 0; k < NUM_OUTPUTS; k++) begin
            load[k] = accept && (broadcast ||
                                 (sel_in_range && (i_select == SEL_W'(k))));
        end
    end

    // Full flags and error pulse. A load wins over a drain, so a channel
    // that drains and reloads at the same edge stays full. This gives full
    // throughput.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            full  <= '0;
            err_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            // All flops then update together from the values before the edge.
            full  <= load | (full & ~i_ready);
            err_q <= drop;
        end
    end

    // Slot storage: written only on load. An empty slot keeps its last word.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            // NOTE: the slot array is reset explicitly, so the output bus
            // reads 0 immediately after reset rather than stale data.
            for (int k = 0; k < NUM_OUTPUTS; k++) begin
                slot[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_OUTPUTS; k++) begin
                if (load[k]) begin
                    slot[k] <= i_data;
                end
            end
        end
    end

    // Flatten the slots onto the output bus, channel 0 in the LSBs.
    for (genvar k = 0; k < NUM_OUTPUTS; k++) begin : g_bus
        assign o_data_bus[k*DATA_WIDTH +: DATA_WIDTH] = slot[k];
    end

    assign o_valid = full;
    assign o_err   = err_q;

endmodule

// File: tb/tb_demux.sv
// tb_demux: directed, self-checking bench for demux.
// It drives two instances:
//   - a 4-channel instance, which is the main target;
//   - a 3-channel instance, which exercises out-of-range selects.
// When DEMUX_BROADCAST_EN is defined, the broadcast path is checked as well.

module tb_demux;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;

    // 4-channel instance signals
    logic        valid4 = 1'b0;
    logic        ready4;
    logic [7:0]  data4 = '0;
    logic [1:0]  sel4 = '0;
    logic [31:0] bus4;
    logic [3:0]  vld4;
    logic [3:0]  rdy4 = '0;
    logic        err4;
    logic        bcast4 = 1'b0;

    // 3-channel instance signals
    logic        valid3 = 1'b0;
    logic        ready3;
    logic [7:0]  data3 = '0;
    logic [1:0]  sel3 = '0;
    logic [23:0] bus3;
    logic [2:0]  vld3;
    logic [2:0]  rdy3 = '0;
    logic        err3;
    logic        bcast3 = 1'b0;

    int checks = 0;
    int failures = 0;

    always #5 i_clk = ~i_clk;

    demux #(.NUM_OUTPUTS(4), .DATA_WIDTH(8)) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
`ifdef DEMUX_BROADCAST_EN
        .i_broadcast(bcast4),
`endif
        .i_valid    (valid4),
        .o_ready    (ready4),
        .i_data     (data4),
        .i_select   (sel4),
        .o_data_bus (bus4),
        .o_valid    (vld4),
        .i_ready    (rdy4),
        .o_err      (err4)
    );

    demux #(.NUM_OUTPUTS(3), .DATA_WIDTH(8)) dut3 (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
`ifdef DEMUX_BROADCAST_EN
        .i_broadcast(bcast3),
`endif
        .i_valid    (valid3),
        .o_ready    (ready3),
        .i_data     (data3),
        .i_select   (sel3),
        .o_data_bus (bus3),
        .o_valid    (vld3),
        .i_ready    (rdy3),
        .o_err      (err3)
    );

    task automatic check(input string tag, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Advance past the next rising edge; registered outputs are then stable.
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Drive inputs on the falling edge; combinational outputs settle by +1.
    task automatic drive4(input logic v, input logic [1:0] s,
                          input logic [7:0] d, input logic [3:0] r);
        @(negedge i_clk);
        valid4 = v;
        sel4   = s;
        data4  = d;
        rdy4   = r;
        #1;
    endtask

    initial begin
        logic [7:0] fill_data [4];
        fill_data[0] = 8'hDD;
        fill_data[1] = 8'hCC;
        fill_data[2] = 8'hBB;
        fill_data[3] = 8'hAA;

        // Reset values are visible while reset is held, before any clock.
        #1;
        check("rst_valid", vld4, 4'b0000);
        check("rst_bus", bus4, 32'h0);
        check("rst_err", err4, 1'b0);
        check("rst_ready", ready4, 1'b1);
        check("rst_valid3", vld3, 3'b000);
        @(negedge i_clk);
        i_rst_n = 1'b1;

        // Fill all four channels while every consumer is stalled.
        for (int i = 0; i < 4; i++) begin
            drive4(1'b1, 2'(i), fill_data[i], 4'b0000);
            check($sformatf("fill_ready%0d", i), ready4, 1'b1);
            tick();
        end
        check("fill_valid", vld4, 4'b1111);
        check("fill_bus", bus4, 32'hAABBCCDD);

        // Channel 1 is full and stalled: the word waits, the slot holds.
        drive4(1'b1, 2'd1, 8'h77, 4'b0000);
        check("stall_ready", ready4, 1'b0);
        tick();
        check("stall_slot", bus4[15:8], 8'hCC);
        check("stall_valid", vld4, 4'b1111);
        // Consumer 1 becomes ready: drain and load happen at the same edge.
        drive4(1'b1, 2'd1, 8'h77, 4'b0010);
        check("release_ready", ready4, 1'b1);
        tick();
        check("release_valid1", vld4[1], 1'b1);
        check("release_slot", bus4[15:8], 8'h77);

        // Stream 0x01..0x10 to channel 2 with every consumer ready.
        for (int n = 1; n <= 16; n++) begin
            drive4(1'b1, 2'd2, 8'(n), 4'b1111);
            check($sformatf("stream_ready%0d", n), ready4, 1'b1);
            tick();
            check($sformatf("stream_valid%0d", n), vld4, 4'b0100);
            check($sformatf("stream_data%0d", n), bus4[23:16], 8'(n));
        end
        drive4(1'b0, 2'd2, 8'h00, 4'b1111);
        tick();
        check("stream_drained", vld4, 4'b0000);
        check("stream_no_err", err4, 1'b0);

        // i_valid low: o_ready still reports the selected channel's state.
        drive4(1'b1, 2'd0, 8'h5A, 4'b0000);
        tick();
        drive4(1'b0, 2'd0, 8'hFF, 4'b0000);
        check("idle_ready_full", ready4, 1'b0);
        tick();
        check("idle_no_change", bus4[7:0], 8'h5A);

        // Two slots full, then reset asserted between edges.
        drive4(1'b1, 2'd3, 8'hE7, 4'b0000);
        tick();
        drive4(1'b0, 2'd0, 8'h00, 4'b0000);
        check("pre_reset_valid", vld4, 4'b1001);
        #1;
        i_rst_n = 1'b0;
        #1;
        check("async_rst_valid", vld4, 4'b0000);
        check("async_rst_bus", bus4, 32'h0);
        @(negedge i_clk);
        i_rst_n = 1'b1;

        // 3-channel instance: load channel 1, then send an out-of-range word.
        @(negedge i_clk);
        valid3 = 1'b1; sel3 = 2'd1; data3 = 8'h11; rdy3 = 3'b000;
        tick();
        @(negedge i_clk);
        valid3 = 1'b1; sel3 = 2'd3; data3 = 8'h55;
        #1;
        check("oor_ready", ready3, 1'b1);
        tick();
        check("oor_err_pulse", err3, 1'b1);
        check("oor_valid", vld3, 3'b010);
        check("oor_bus", bus3, 24'h001100);
        @(negedge i_clk);
        valid3 = 1'b0;
        tick();
        check("oor_err_clear", err3, 1'b0);

`ifdef DEMUX_BROADCAST_EN
        // Broadcast waits for every channel; channel 1 is full and stalled.
        drive4(1'b1, 2'd1, 8'h99, 4'b0000);
        tick();
        @(negedge i_clk);
        bcast4 = 1'b1; valid4 = 1'b1; sel4 = 2'd3; data4 = 8'h3C; rdy4 = 4'b0000;
        #1;
        check("bcast_blocked", ready4, 1'b0);
        tick();
        check("bcast_hold_valid", vld4, 4'b0010);
        @(negedge i_clk);
        rdy4 = 4'b0010;
        #1;
        check("bcast_ready", ready4, 1'b1);
        tick();
        check("bcast_valid", vld4, 4'b1111);
        check("bcast_bus", bus4, 32'h3C3C3C3C);
        check("bcast_no_err", err4, 1'b0);
        @(negedge i_clk);
        bcast4 = 1'b0; valid4 = 1'b0; rdy4 = 4'b0000;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
